// File: rtl/poly_tone_synth.sv
// rtl/poly_tone_synth.sv - NUM_CH-channel square-wave synth with weighted mix and sigma-delta output
// Retunes on active channels wait in a one-entry shadow until the next toggle edge.
module poly_tone_synth #(
  parameter  int NUM_CH = 6,
  parameter  int HP_W   = 16,
  parameter  int VOL_W  = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int MIX_W  = VOL_W + $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [HP_W-1:0]   cfg_half_period,
  input  logic [VOL_W-1:0]  cfg_volume,
  input  logic [NUM_CH-1:0] note_en,
  output logic [NUM_CH-1:0] ch_level,
  output logic [MIX_W-1:0]  mix_out,
  output logic              sound_out
);

  localparam logic [CH_W:0] NUM_CH_X = (CH_W + 1)'(NUM_CH);

  logic [HP_W-1:0]   hp_q     [NUM_CH];
  logic [HP_W-1:0]   hp_d     [NUM_CH];
  logic [VOL_W-1:0]  vol_q    [NUM_CH];
  logic [VOL_W-1:0]  vol_d    [NUM_CH];
  logic [HP_W-1:0]   sh_hp_q  [NUM_CH];
  logic [HP_W-1:0]   sh_hp_d  [NUM_CH];
  logic [VOL_W-1:0]  sh_vol_q [NUM_CH];
  logic [VOL_W-1:0]  sh_vol_d [NUM_CH];
  logic [HP_W-1:0]   cnt_q    [NUM_CH];
  logic [HP_W-1:0]   cnt_d    [NUM_CH];
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] ch_level_q, ch_level_d;
  logic [MIX_W-1:0]  mix_q, mix_d;
  logic [MIX_W-1:0]  acc_q, acc_d;
  logic              sound_q, sound_d;

  logic              sel_pending;
  logic              cfg_in_range;
  logic              cfg_accept;
  logic [NUM_CH-1:0] ch_active;
  logic [NUM_CH-1:0] ch_wrap;
  logic [NUM_CH-1:0] ch_wr;
  logic [MIX_W:0]    sd_sum;

  // Out-of-range channel numbers never stall; they are accepted and dropped.
  always_comb begin
    sel_pending = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) sel_pending = pending_q[i];
    end
  end

  assign cfg_in_range = ({1'b0, cfg_ch} < NUM_CH_X);
  assign cfg_ready    = !reset && (!cfg_in_range || !sel_pending);
  assign cfg_accept   = cfg_valid && cfg_ready;

  always_comb begin
    ch_active = '0;
    ch_wrap   = '0;
    ch_wr     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_active[i] = note_en[i] && (hp_q[i] != '0);
      ch_wrap[i]   = (cnt_q[i] == hp_q[i] - HP_W'(1));
      ch_wr[i]     = cfg_accept && (cfg_ch == CH_W'(i));
    end
  end

  always_comb begin
    hp_d       = hp_q;
    vol_d      = vol_q;
    sh_hp_d    = sh_hp_q;
    sh_vol_d   = sh_vol_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    ch_level_d = ch_level_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_active[i]) begin
        if (ch_wrap[i]) begin
          ch_level_d[i] = ~ch_level_q[i];
          cnt_d[i]      = '0;
          if (pending_q[i]) begin
            hp_d[i]      = sh_hp_q[i];
            vol_d[i]     = sh_vol_q[i];
            pending_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + HP_W'(1);
        end
        // A write landing on a toggle edge still waits for the following toggle.
        if (ch_wr[i]) begin
          sh_hp_d[i]   = cfg_half_period;
          sh_vol_d[i]  = cfg_volume;
          pending_d[i] = 1'b1;
        end
      end else begin
        ch_level_d[i] = 1'b0;
        cnt_d[i]      = '0;
        if (pending_q[i]) begin
          hp_d[i]      = sh_hp_q[i];
          vol_d[i]     = sh_vol_q[i];
          pending_d[i] = 1'b0;
        end
        if (ch_wr[i]) begin
          hp_d[i]  = cfg_half_period;
          vol_d[i] = cfg_volume;
        end
      end
    end
  end

  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_level_q[i]) mix_d = mix_d + MIX_W'(vol_q[i]);
    end
  end

  // First-order sigma-delta: the accumulator carry is the output bit.
  assign sd_sum  = {1'b0, acc_q} + {1'b0, mix_q};
  assign acc_d   = sd_sum[MIX_W-1:0];
  assign sound_d = sd_sum[MIX_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        hp_q[i]     <= '0;
        vol_q[i]    <= '0;
        sh_hp_q[i]  <= '0;
        sh_vol_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      pending_q  <= '0;
      ch_level_q <= '0;
      mix_q      <= '0;
      acc_q      <= '0;
      sound_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        hp_q[i]     <= hp_d[i];
        vol_q[i]    <= vol_d[i];
        sh_hp_q[i]  <= sh_hp_d[i];
        sh_vol_q[i] <= sh_vol_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      pending_q  <= pending_d;
      ch_level_q <= ch_level_d;
      mix_q      <= mix_d;
      acc_q      <= acc_d;
      sound_q    <= sound_d;
    end
  end

  assign ch_level  = ch_level_q;
  assign mix_out   = mix_q;
  assign sound_out = sound_q;

endmodule

// File: tb/tb_poly_tone_synth.sv
// tb/tb_poly_tone_synth.sv - directed scoreboard bench for poly_tone_synth
module tb_poly_tone_synth;

  localparam int NUM_CH = 6;
  localparam int HP_W   = 16;
  localparam int VOL_W  = 4;
  localparam int CH_W   = 3;
  localparam int MIX_W  = 7;

  logic              clk;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [HP_W-1:0]   cfg_half_period;
  logic [VOL_W-1:0]  cfg_volume;
  logic [NUM_CH-1:0] note_en;
  logic [NUM_CH-1:0] ch_level;
  logic [MIX_W-1:0]  mix_out;
  logic              sound_out;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int mix_exp_q[$];
  int tone_pat[12] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
  int n;
  int ones;

  poly_tone_synth #(.NUM_CH(NUM_CH), .HP_W(HP_W), .VOL_W(VOL_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_ch          (cfg_ch),
    .cfg_half_period (cfg_half_period),
    .cfg_volume      (cfg_volume),
    .note_en         (note_en),
    .ch_level        (ch_level),
    .mix_out         (mix_out),
    .sound_out       (sound_out)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int ch, input int hp, input int vol);
    int w;
    cfg_valid       = 1'b1;
    cfg_ch          = CH_W'(ch);
    cfg_half_period = HP_W'(hp);
    cfg_volume      = VOL_W'(vol);
    #1;
    w = 0;
    while (cfg_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("wr_ready", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_half_period = '0; cfg_volume = '0; note_en = '0;
    step(); step();
    check("rst_lvl", ch_level, 0);
    check("rst_mix", mix_out, 0);
    check("rst_snd", sound_out, 0);
    check("rst_rdy", cfg_ready, 0);
    reset = 1'b0;
    #1 check("rel_rdy", cfg_ready, 1);
    step();

    // reset in the middle of a running note with a pending retune
    cfg_write(0, 2, 5);
    note_en = 6'b000001;
    repeat (6) step();
    cfg_write(0, 3, 7);
    #1 check("pend_rdy", cfg_ready, 0);
    reset = 1'b1;
    #1 check("rst_rdy_mid", cfg_ready, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_mid_lvl", ch_level, 0);
      check("rst_mid_mix", mix_out, 0);
      check("rst_mid_snd", sound_out, 0);
      check("rst_mid_rdy", cfg_ready, 0);
    end
    reset = 1'b0;
    #1 check("rel_rdy2", cfg_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("hp0_silent", ch_level, 0);
      check("hp0_mix", mix_out, 0);
    end

    // basic tone hp=3 vol=15
    note_en = '0;
    cfg_write(0, 3, 15);
    note_en = 6'b000001;
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(tone_pat[k]);
      mix_exp_q.push_back(k == 0 ? 0 : 15 * tone_pat[k-1]);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      check("tone_lvl", ch_level[0], exp_q.pop_front());
      check("tone_mix", mix_out, mix_exp_q.pop_front());
    end
    note_en = '0;
    step();
    check("dis_lvl", ch_level[0], 0);

    // glitch-free retune of ch1 from hp=10 to hp=4
    cfg_write(1, 10, 3);
    note_en = 6'b000010;
    for (int k = 0; k < 31; k++)
      exp_q.push_back((k >= 9 && k <= 18) || (k >= 23 && k <= 26) ? 1 : 0);
    for (int k = 0; k < 31; k++) begin
      step();
      check("retune_lvl", ch_level[1], exp_q.pop_front());
      if (k == 14) begin
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_half_period = 16'd4; cfg_volume = 4'd3;
        #1 check("rt_rdy_first", cfg_ready, 1);
      end else if (k == 15 || k == 17 || k == 18) begin
        cfg_ch = 3'd1; cfg_half_period = 16'd7; cfg_volume = 4'd3;
        #1 check("rt_stall", cfg_ready, 0);
      end else if (k == 16) begin
        cfg_ch = 3'd2; cfg_half_period = 16'd5; cfg_volume = 4'd2;
        #1 check("rt_ch2_rdy", cfg_ready, 1);
      end else if (k == 19) begin
        #1 check("rt_rdy_back", cfg_ready, 1);
        cfg_valid = 1'b0;
      end
    end
    note_en = '0;
    step();

    // out-of-range channel write is accepted and dropped
    cfg_valid = 1'b1; cfg_ch = 3'd7; cfg_half_period = 16'd9; cfg_volume = 4'd9;
    #1 check("ch7_rdy", cfg_ready, 1);
    step();
    cfg_valid = 1'b0; cfg_ch = 3'd0;
    note_en = 6'b000001;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("ch7_keep_lvl", ch_level[0], exp_q.pop_front());
    end
    check("ch7_keep_vol", mix_out, 15);

    // dropping note_en mid-half zeroes the level and applies the shadow
    cfg_write(0, 2, 6);
    #1 check("drop_pend_rdy", cfg_ready, 0);
    check("drop_pre_lvl", ch_level[0], 1);
    note_en = '0;
    step();
    check("drop_lvl", ch_level[0], 0);
    #1 check("drop_rdy", cfg_ready, 1);
    note_en = 6'b000001;
    step(); check("reen_lvl0", ch_level[0], 0);
    step(); check("reen_lvl1", ch_level[0], 1);
    step(); check("reen_mix", mix_out, 6);
    note_en = '0;
    step();

    // mix ceiling: all channels hp=1 vol=15
    for (int c = 0; c < NUM_CH; c++) cfg_write(c, 1, 15);
    note_en = 6'h3F;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back((k % 2 == 0) ? 63 : 0);
      mix_exp_q.push_back((k % 2 == 1) ? 90 : 0);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      check("ceil_lvl", ch_level, exp_q.pop_front());
      check("ceil_mix", mix_out, mix_exp_q.pop_front());
    end
    note_en = '0;
    step();

    // sigma-delta density for mix=8
    cfg_write(0, 1000, 8);
    note_en = 6'b000001;
    n = 0;
    while (ch_level[0] !== 1'b1 && n < 1100) begin
      step();
      n++;
    end
    check("sd_rise", ch_level[0], 1);
    check("sd_rise_cyc", n, 1000);
    repeat (4) step();
    check("sd_mix", mix_out, 8);
    ones = 0;
    for (int k = 0; k < 128; k++) begin
      step();
      ones += int'(sound_out);
    end
    check("sd_ones", ones, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
